// File: rtl/alu_unit.sv
// alu_unit: multi-cycle 8/16-bit ALU with a flag register and valid/ready handshake.
// Define ALU_UNIT_DAA_EN to enable decimal adjust (opcode 0x14, 8-bit only).
module alu_unit #(
    parameter int ALU_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [4:0]           opcode,
    input  logic [ALU_WIDTH-1:0] a,
    input  logic [ALU_WIDTH-1:0] b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ALU_WIDTH-1:0] result,
    output logic [7:0]           flags
);
    localparam int W  = ALU_WIDTH;
    localparam int HB = (W == 16) ? 11 : 3;
    localparam int CW = $clog2(W);

    localparam logic [4:0] OP_ADD = 5'h00, OP_ADC = 5'h01, OP_SUB = 5'h02;
    localparam logic [4:0] OP_SBC = 5'h03, OP_AND = 5'h04, OP_OR  = 5'h05;
    localparam logic [4:0] OP_XOR = 5'h06, OP_CP  = 5'h07, OP_INC = 5'h08;
    localparam logic [4:0] OP_DEC = 5'h09, OP_RLC = 5'h0A, OP_RRC = 5'h0B;
    localparam logic [4:0] OP_RL  = 5'h0C, OP_RR  = 5'h0D, OP_SLA = 5'h0E;
    localparam logic [4:0] OP_SRA = 5'h0F, OP_SRL = 5'h10, OP_BIT = 5'h11;
    localparam logic [4:0] OP_SET = 5'h12, OP_RES = 5'h13;
`ifdef ALU_UNIT_DAA_EN
    localparam logic [4:0] OP_DAA = 5'h14;
`endif

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    state_t state, state_nx;

    logic [4:0]    op;
    logic [CW-1:0] cnt;
    logic          cy;
    logic [CW-1:0] k;
    logic          is_sh;
    logic          sub, cin, vf;
    logic [W-1:0]  opb, nr;
    logic [7:0]    nf;
    logic [W:0]    sum;
    logic [HB+1:0] hsum;
    logic [W:0]    stp;

    function automatic logic [7:0] pack(input logic [W-1:0] r, input logic h,
                                        input logic pv, input logic n,
                                        input logic c);
        return {r[W-1], r == '0, 1'b0, h, 1'b0, pv, n, c};
    endfunction

    // One shift/rotate step; returns {carry_out, value}.
    function automatic logic [W:0] step(input logic [4:0] o,
                                        input logic [W-1:0] r, input logic c);
        logic [W:0] s;
        case (o)
            OP_RLC:  s = {r[W-1], r[W-2:0], r[W-1]};
            OP_RRC:  s = {r[0], r[0], r[W-1:1]};
            OP_RL:   s = {r[W-1], r[W-2:0], c};
            OP_RR:   s = {r[0], c, r[W-1:1]};
            OP_SLA:  s = {r[W-1], r[W-2:0], 1'b0};
            OP_SRA:  s = {r[0], r[W-1], r[W-1:1]};
            default: s = {r[0], 1'b0, r[W-1:1]};
        endcase
        return s;
    endfunction

    assign k     = b[CW-1:0];
    assign is_sh = (opcode >= OP_RLC) && (opcode <= OP_SRL);
    assign stp   = step(op, result, cy);

    always_comb begin
        opb = b;
        sub = 1'b0;
        cin = 1'b0;
        case (opcode)
            OP_ADC:        cin = flags[0];
            OP_SUB, OP_CP: sub = 1'b1;
            OP_SBC: begin
                sub = 1'b1;
                cin = flags[0];
            end
            OP_INC:        opb = W'(1);
            OP_DEC: begin
                sub = 1'b1;
                opb = W'(1);
            end
            default: ;
        endcase
        if (sub) begin
            sum  = {1'b0, a} - {1'b0, opb} - {{W{1'b0}}, cin};
            hsum = {1'b0, a[HB:0]} - {1'b0, opb[HB:0]} - {{(HB+1){1'b0}}, cin};
            vf   = (a[W-1] != opb[W-1]) && (sum[W-1] != a[W-1]);
        end else begin
            sum  = {1'b0, a} + {1'b0, opb} + {{W{1'b0}}, cin};
            hsum = {1'b0, a[HB:0]} + {1'b0, opb[HB:0]} + {{(HB+1){1'b0}}, cin};
            vf   = (a[W-1] == opb[W-1]) && (sum[W-1] != a[W-1]);
        end
    end

`ifdef ALU_UNIT_DAA_EN
    logic [W-1:0] daa_adj, daa_r;
    logic         daa_c, daa_h;

    always_comb begin
        daa_adj = '0;
        if (flags[4] || (a[3:0] > 4'd9)) daa_adj[3:0] = 4'h6;
        daa_c = flags[0] || (a[7:0] > 8'h99);
        if (daa_c) daa_adj[7:4] = 4'h6;
        daa_h = flags[1] ? (flags[4] && (a[3:0] < 4'd6)) : (a[3:0] > 4'd9);
        daa_r = flags[1] ? (a - daa_adj) : (a + daa_adj);
    end
`endif

    always_comb begin
        nr = '0;
        nf = flags;
        case (opcode)
            OP_ADD, OP_ADC, OP_SUB, OP_SBC: begin
                nr = sum[W-1:0];
                nf = pack(nr, hsum[HB+1], vf, sub, sum[W]);
            end
            OP_CP: begin
                nr = a;
                nf = pack(sum[W-1:0], hsum[HB+1], vf, 1'b1, sum[W]);
            end
            OP_INC, OP_DEC: begin
                nr = sum[W-1:0];
                nf = pack(nr, hsum[HB+1], vf, sub, flags[0]);
            end
            OP_AND: begin
                nr = a & b;
                nf = pack(nr, 1'b1, ~^nr, 1'b0, 1'b0);
            end
            OP_OR: begin
                nr = a | b;
                nf = pack(nr, 1'b0, ~^nr, 1'b0, 1'b0);
            end
            OP_XOR: begin
                nr = a ^ b;
                nf = pack(nr, 1'b0, ~^nr, 1'b0, 1'b0);
            end
            // Shift by zero finishes here; nonzero counts refine flags in SHIFT.
            OP_RLC, OP_RRC, OP_RL, OP_RR, OP_SLA, OP_SRA, OP_SRL: begin
                nr = a;
                nf = pack(a, 1'b0, ~^a, 1'b0, flags[0]);
            end
            OP_BIT: begin
                nr = a;
                nf = {flags[7], ~a[k], 1'b0, 1'b1, 1'b0, flags[2], 1'b0, flags[0]};
            end
            OP_SET: nr = a | (W'(1) << k);
            OP_RES: nr = a & ~(W'(1) << k);
`ifdef ALU_UNIT_DAA_EN
            OP_DAA: begin
                if (W == 8) begin
                    nr = daa_r;
                    nf = pack(daa_r, daa_h, ~^daa_r, flags[1], daa_c);
                end
            end
`endif
            default: ;
        endcase
    end

    always_comb begin
        state_nx  = state;
        in_ready  = rst_n && (state == IDLE);
        out_valid = (state == DONE);
        unique case (state)
            IDLE:    if (in_valid) state_nx = (is_sh && k != '0) ? SHIFT : DONE;
            SHIFT:   if (cnt == CW'(1)) state_nx = DONE;
            DONE:    if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            result <= '0;
            flags  <= '0;
            op     <= '0;
            cnt    <= '0;
            cy     <= 1'b0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        op     <= opcode;
                        cnt    <= k;
                        cy     <= flags[0];
                        result <= nr;
                        if (!(is_sh && k != '0)) flags <= nf;
                    end
                end
                SHIFT: begin
                    result <= stp[W-1:0];
                    cy     <= stp[W];
                    cnt    <= cnt - CW'(1);
                    if (cnt == CW'(1))
                        flags <= pack(stp[W-1:0], 1'b0, ~^stp[W-1:0], 1'b0, stp[W]);
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_unit.sv
// tb_alu_unit: scoreboard bench for alu_unit, random stimulus against an
// arithmetic reference model; a 16-bit instance covers the wide datapath.
module tb_alu_unit;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, in_valid, in_ready, out_valid, out_ready;
    logic [4:0]  opcode;
    logic [7:0]  a, b, result, flags;
    logic        v16, rdy16, ov16;
    logic [4:0]  op16;
    logic [15:0] a16, b16, r16;
    logic [7:0]  f16;

    alu_unit #(.ALU_WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .a(a), .b(b), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .flags(flags)
    );

    alu_unit #(.ALU_WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(v16), .in_ready(rdy16),
        .opcode(op16), .a(a16), .b(b16), .out_valid(ov16),
        .out_ready(1'b1), .result(r16), .flags(f16)
    );

    typedef struct {
        int r;
        int f;
        int lat;
        int acc;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;
    int   hold   = 0;
    int   mf     = 0;
    int   mf16   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int sgn(input int x, input int w);
        return (x >= (1 << (w - 1))) ? x - (1 << w) : x;
    endfunction

    function automatic int pk(input int w, input int r, input int h,
                              input int v, input int n, input int c);
        return ((r >= (1 << (w - 1))) << 7) | ((r == 0) << 6) | (h << 4)
             | (v << 2) | (n << 1) | c;
    endfunction

    // Reference model: result, flags and latency from the operation rules.
    function automatic void model(input int w, input int op, input int av,
                                  input int bv, input int fi, output int r,
                                  output int fo, output int lat);
        int m, msb, hm, c, y, ci, full, h, v, cc, k, hi, lo;
        m   = (1 << w) - 1;
        msb = 1 << (w - 1);
        hm  = (1 << (w - 4)) - 1;
        c   = fi & 1;
        k   = bv % w;
        r   = 0;
        fo  = fi;
        lat = 1;
        case (op)
            0, 1, 8: begin
                y    = (op == 8) ? 1 : bv;
                ci   = (op == 1) ? c : 0;
                full = av + y + ci;
                r    = full & m;
                h    = ((av & hm) + (y & hm) + ci) > hm;
                v    = sgn(av, w) + sgn(y, w) + ci;
                v    = (v > msb - 1) || (v < -msb);
                cc   = (op == 8) ? c : (full > m);
                fo   = pk(w, r, h, v, 0, cc);
            end
            2, 3, 7, 9: begin
                y    = (op == 9) ? 1 : bv;
                ci   = (op == 3) ? c : 0;
                full = av - y - ci;
                r    = full & m;
                h    = ((av & hm) - (y & hm) - ci) < 0;
                v    = sgn(av, w) - sgn(y, w) - ci;
                v    = (v > msb - 1) || (v < -msb);
                cc   = (op == 9) ? c : (full < 0);
                fo   = pk(w, r, h, v, 1, cc);
                if (op == 7) r = av;
            end
            4, 5, 6: begin
                r  = (op == 4) ? (av & bv) : (op == 5) ? (av | bv) : (av ^ bv);
                fo = pk(w, r, op == 4, ($countones(r) % 2) == 0, 0, 0);
            end
            10, 11, 12, 13, 14, 15, 16: begin
                r  = av;
                cc = c;
                for (int i = 0; i < k; i++) begin
                    hi = (r >> (w - 1)) & 1;
                    lo = r & 1;
                    case (op)
                        10: r = ((r << 1) | hi) & m;
                        11: r = (r >> 1) | (lo << (w - 1));
                        12: r = ((r << 1) | cc) & m;
                        13: r = (r >> 1) | (cc << (w - 1));
                        14: r = (r << 1) & m;
                        15: r = (r >> 1) | (hi << (w - 1));
                        default: r = r >> 1;
                    endcase
                    cc = (op == 10 || op == 12 || op == 14) ? hi : lo;
                end
                fo  = pk(w, r, 0, ($countones(r) % 2) == 0, 0, cc);
                lat = (k == 0) ? 1 : k + 1;
            end
            17: begin
                r  = av;
                fo = (fi & 'h85) | ((((av >> k) & 1) == 0) << 6) | 'h10;
            end
            18: r = av | (1 << k);
            19: r = av & ~(1 << k) & m;
            default: ;
        endcase
    endfunction

    // Monitor: pops an expectation when a new result appears, then
    // checks it stays stable while the consumer stalls.
    logic pv  = 1'b0;
    logic phs = 1'b0;
    int   hr, hf;
    exp_t e;

    always @(negedge clk) begin
        if (phs && rst_n) chk("idle_after_release", in_ready, 1);
        if (out_valid === 1'b1) begin
            chk("ready_while_busy", in_ready, 0);
            if (!pv) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out: result 0x%0h flags 0x%0h, none pending",
                             result, flags);
                end else begin
                    e = q.pop_front();
                    chk("result", result, e.r);
                    chk("flags", flags, e.f);
                    chk("latency", cyc - e.acc, e.lat);
                end
                hr = result;
                hf = flags;
            end else begin
                chk("hold_result", result, hr);
                chk("hold_flags", flags, hf);
            end
        end
        pv  = (out_valid === 1'b1);
        phs = (out_valid === 1'b1) && out_ready;
    end

    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (hold > 0) begin
                out_ready = 1'b0;
                if (out_valid) hold--;
            end else begin
                out_ready = ($urandom_range(0, 3) != 0);
            end
        end
    end

    task automatic issue(input int op, input int av, input int bv, input bit track);
        int r, f, lat;
        int n = 0;
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        opcode   = op[4:0];
        a        = av[7:0];
        b        = bv[7:0];
        forever begin
            @(negedge clk);
            if (in_ready) break;
            if (++n > 200) begin
                checks++;
                errors++;
                $display("FAIL accept_timeout: op 0x%0h never accepted", op);
                break;
            end
        end
        if (track) begin
            model(8, op, av, bv, mf, r, f, lat);
            mf = f;
            q.push_back('{r, f, lat, cyc});
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((q.size() != 0 || out_valid) && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", int'(q.size() != 0 || out_valid), 0);
    endtask

    task automatic run16(input int op, input int av, input int bv);
        int r, f, lat;
        int n = 0;
        model(16, op, av, bv, mf16, r, f, lat);
        mf16 = f;
        @(posedge clk);
        #1;
        v16  = 1'b1;
        op16 = op[4:0];
        a16  = av[15:0];
        b16  = bv[15:0];
        while (!rdy16 && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        @(posedge clk);
        #1;
        v16 = 1'b0;
        n   = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ov16 && n < 40);
        chk("w16_result", r16, r);
        chk("w16_flags", f16, f);
        chk("w16_latency", n, lat);
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int op, av, bv;
        bit seen;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        opcode   = '0;
        a        = '0;
        b        = '0;
        v16      = 1'b0;
        op16     = '0;
        a16      = '0;
        b16      = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("ready_in_reset", in_ready, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_ready", in_ready, 1);
        chk("reset_valid", out_valid, 0);
        chk("reset_result", result, 0);
        chk("reset_flags", flags, 0);

        issue(0, 'h7F, 'h01, 1);
        issue(2, 'h00, 'h01, 1);
        issue(3, 'h00, 'h00, 1);
        issue(10, 'h81, 3, 1);
        issue(20, 'h55, 'h01, 1);
        issue(31, 'hAA, 'h02, 1);
        drain();
        hold = 5;
        issue(0, 'h12, 'h34, 1);
        drain();

        issue(10, 'hA5, 5, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        chk("ready_in_midreset", in_ready, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        mf    = 0;
        @(posedge clk);
        #1;
        chk("abort_ready", in_ready, 1);
        chk("abort_flags", flags, 0);
        chk("abort_result", result, 0);
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        chk("abort_no_valid", seen, 0);

        for (int i = 0; i < 200; i++) begin
            op = $urandom_range(0, 23);
            av = $urandom_range(0, 255);
            bv = $urandom_range(0, 255);
            if ($urandom_range(0, 9) == 0) hold = $urandom_range(1, 4);
            issue(op, av, bv, 1);
        end
        drain();

        run16(0, 'h0FFF, 'h0001);
        run16(2, 'h8000, 'h0001);
        run16(10, 'h8001, 'h0013);
        for (int i = 0; i < 12; i++)
            run16($urandom_range(0, 19), $urandom_range(0, 65535),
                  $urandom_range(0, 65535));

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/alu_unit.md
ALU_UNIT -- requirements
Module: alu_unit

Interface
REQ-001 Parameter: ALU_WIDTH, default 8, datapath width; legal values 8 and 16.
REQ-002 clk  input  1  single rising-edge clock for all state.
REQ-003 rst_n  input  1  synchronous reset, active-low.
REQ-004 in_valid  input  1  request presented.
REQ-005 in_ready  output  1  unit can accept a request.
REQ-006 opcode  input  5  operation select.
REQ-007 a, b  input  ALU_WIDTH each  operands.
REQ-008 out_valid  output  1  result and flags valid.
REQ-009 out_ready  input  1  consumer accepts the result.
REQ-010 result  output  ALU_WIDTH  registered result.
REQ-011 flags  output  8  registered flag register: 7 S, 6 Z, 5 0, 4 H, 3 0, 2 P/V, 1 N, 0 C.

Function
REQ-012 Opcodes SHALL be: 00 ADD, 01 ADC, 02 SUB, 03 SBC, 04 AND, 05 OR, 06 XOR, 07 CP, 08 INC, 09 DEC, 0A RLC, 0B RRC, 0C RL, 0D RR, 0E SLA, 0F SRA, 10 SRL, 11 BIT, 12 SET, 13 RES, 14 DAA; all others illegal.
REQ-013 FSM states SHALL be IDLE, SHIFT and DONE.
REQ-014 in_ready SHALL be 1 only in IDLE; a request is accepted on a clock edge where in_valid and in_ready are both 1, and the operands and opcode are captured.
REQ-015 Non-shift ops SHALL go IDLE->DONE, with out_valid=1 in the cycle after acceptance (latency 1).
REQ-016 Shift/rotate ops (0A-10) SHALL use k = b mod ALU_WIDTH and shift one bit per cycle in SHIFT: k=0 goes IDLE->DONE with result=a and latency 1; otherwise the latency is k+1 cycles.
REQ-017 In DONE, out_valid SHALL hold result/flags stable until out_ready=1, then go to IDLE on that edge.
REQ-018 ADC/SBC SHALL use the flag register's C as carry/borrow-in; the flags value from the previous operation persists until it is overwritten.
REQ-019 Arithmetic: C = carry/borrow out of the MSB; H = carry out of bit 3 (ALU_WIDTH=8) or bit 11 (16); P/V = signed overflow; N=1 for SUB/SBC/CP/DEC, else 0.
REQ-020 AND/OR/XOR: C=0, N=0, H=1 for AND and 0 otherwise, P/V = even parity of result.
REQ-021 CP: result=a; flags as SUB a-b.
REQ-022 INC/DEC: C SHALL be unchanged; other flags as ADD/SUB with operand 1.
REQ-023 Shifts: C = last bit shifted out (unchanged if k=0), H=0, N=0, P/V = parity; RL/RR rotate through C on every step.
REQ-024 S = result MSB and Z = (result==0) for all ops except BIT/SET/RES.
REQ-025 BIT: result=a; Z = ~a[b mod ALU_WIDTH]; H=1; N=0; S, P/V and C unchanged.
REQ-026 SET/RES: result = a with bit (b mod ALU_WIDTH) set/cleared; flags unchanged.
REQ-027 Illegal opcode: result=0, flags unchanged, latency 1.

Reset
REQ-028 While rst_n=0 at a clock edge: state=IDLE, result=0, flags=0x00, out_valid=0.
REQ-029 in_ready SHALL be 0 while rst_n=0.
REQ-030 Reset mid-SHIFT or in DONE SHALL abort the operation, discard the pending result and produce no out_valid.

Configuration
REQ-031 With ALU_UNIT_DAA_EN defined: DAA (0x14) decimal-adjusts a using the N, H and C flags; ALU_WIDTH=8 only; latency 1.
REQ-032 Without ALU_UNIT_DAA_EN: 0x14 is treated as an illegal opcode (REQ-027).

Verification
REQ-033 W=8, ADD a=0x7F b=0x01 -> after 1 cycle result=0x80, flags=0x94 (S,H,V).
REQ-034 W=8, flags C=1, SBC a=0x00 b=0x00 -> result=0xFF, flags=0x93 (S,H,N,C).
REQ-035 W=8, RLC a=0x81 b=3 -> out_valid after 4 cycles, result=0x0C, C=0, P/V=1.
REQ-036 out_ready held 0 for 5 cycles -> result/flags stable, in_ready=0; release -> IDLE on the next edge.
REQ-037 rst_n=0 during SHIFT (k=5) -> out_valid never asserts, flags=0x00, in_ready=1 one cycle after rst_n=1.
REQ-038 W=16, ADD a=0x0FFF b=0x0001 -> result=0x1000, H=1, C=0.
